// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling shuffle over a 256-byte S memory that already holds S[k]=k.
// Each iteration reads S[i] and S[j], then writes them back swapped (6 cycles per i).
module ksa_shuffle (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [23:0] secret_key,
    input  logic [7:0]  q,
    output logic        done,
    output logic [7:0]  address,
    output logic [7:0]  data,
    output logic        wren,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_SI    = 3'd1,
        S_LATCH_SI = 3'd2,
        S_RD_SJ    = 3'd3,
        S_LATCH_SJ = 3'd4,
        S_WR_I     = 3'd5,
        S_WR_J     = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t     state, state_next;
    logic [7:0] i, j, si, sj;
    logic [1:0] kidx;       // tracks i mod 3 without a divider
    logic [7:0] key_byte;

    // Handshake: start is a request level sampled only in IDLE; done is a level
    // held in DONE until start drops, after which the block returns to IDLE.

    always_comb begin
        key_byte = secret_key[23:16];
        case (kidx)
            2'd1:    key_byte = secret_key[15:8];
            2'd2:    key_byte = secret_key[7:0];
            default: key_byte = secret_key[23:16];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            i     <= 8'd0;
            j     <= 8'd0;
            si    <= 8'd0;
            sj    <= 8'd0;
            kidx  <= 2'd0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        i    <= 8'd0;
                        j    <= 8'd0;
                        kidx <= 2'd0;
                    end
                end
                S_LATCH_SI: begin
                    si <= q;
                    j  <= j + q + key_byte;
                end
                S_LATCH_SJ: begin
                    sj <= q;
                end
                S_WR_J: begin
                    if (i != 8'd255) begin
                        i    <= i + 8'd1;
                        kidx <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded purely from registered state, so reset clears them at once.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        wren       = 1'b0;
        address    = 8'd0;
        data       = 8'd0;
        case (state)
            S_IDLE:     if (start) state_next = S_RD_SI;
            S_RD_SI: begin
                address    = i;
                state_next = S_LATCH_SI;
            end
            S_LATCH_SI: state_next = S_RD_SJ;
            S_RD_SJ: begin
                address    = j;
                state_next = S_LATCH_SJ;
            end
            S_LATCH_SJ: state_next = S_WR_I;
            S_WR_I: begin
                address    = i;
                data       = sj;
                wren       = 1'b1;
                state_next = S_WR_J;
            end
            S_WR_J: begin
                address    = j;
                data       = si;
                wren       = 1'b1;
                state_next = (i == 8'd255) ? S_DONE : S_RD_SI;
            end
            S_DONE: begin
                done = 1'b1;
                if (!start) state_next = S_IDLE;
            end
            default:    state_next = S_IDLE;
        endcase
    end

    assign state_dbg = state;

endmodule
